// File: rtl/fir_out_conditioner.sv
// Output conditioner for the transposed FIR: drops pipeline-fill samples, decimates,
// rescales with round-half-up and saturation, and buffers results in a small FIFO.
module fir_out_conditioner #(
  parameter int IN_W   = 18,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 6,
  parameter int DECIM  = 2,
  parameter int WARMUP = 10,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_en,
  input  logic [IN_W-1:0]          din,
  output logic [OUT_W-1:0]         dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     sat
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [IN_W:0]    RND  = (SHIFT > 0) ? ((IN_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0))
                                                   : (IN_W+1)'(0);
  localparam logic [OUT_W-1:0] MAXV = '1;

  // Returns {clipped, value}; the extra sum bit keeps the rounding carry.
  function automatic logic [OUT_W:0] scale(input logic [IN_W-1:0] d);
    logic [IN_W:0] sum;
    logic [IN_W:0] q;
    sum = {1'b0, d} + RND;
    q   = sum >> SHIFT;
    if (|q[IN_W:OUT_W]) begin
      scale = {1'b1, MAXV};
    end else begin
      scale = {1'b0, q[OUT_W-1:0]};
    end
  endfunction

  logic [WW-1:0]    warm_r;
  logic [PW-1:0]    phase_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [OUT_W-1:0] mem_r [DEPTH];

  logic             warm_acc_s;
  logic             post_acc_s;
  logic             keep_s;
  logic [OUT_W:0]   scaled_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [LW-1:0]    level_nxt_s;
  logic [AW-1:0]    rd_nxt_s;
  logic [OUT_W-1:0] head_s;

  // Accept/keep decisions, FIFO control and the next head-of-queue value.
  always_comb begin
    warm_acc_s  = in_en && (warm_r != WW'(WARMUP));
    post_acc_s  = in_en && (warm_r == WW'(WARMUP));
    keep_s      = post_acc_s && (phase_r == PW'(0));
    scaled_s    = scale(din);
    full_s      = (level == LW'(DEPTH));
    pop_s       = out_valid && out_ready;
    push_s      = keep_s && (!full_s || pop_s);
    drop_s      = keep_s && full_s && !pop_s;
    level_nxt_s = level + LW'(push_s) - LW'(pop_s);
    if (pop_s) begin
      rd_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
    // When the queue would be empty before this push, the new sample becomes the head.
    if (pop_s ? (level == LW'(1)) : (level == LW'(0))) begin
      head_s = scaled_s[OUT_W-1:0];
    end else begin
      head_s = mem_r[rd_nxt_s];
    end
  end

  // Counters, FIFO storage, registered outputs and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_r    <= WW'(0);
      phase_r   <= PW'(0);
      wr_ptr_r  <= AW'(0);
      rd_ptr_r  <= AW'(0);
      level     <= LW'(0);
      out_valid <= 1'b0;
      dout      <= OUT_W'(0);
      ovf       <= 1'b0;
      sat       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= OUT_W'(0);
      end
    end else begin
      if (warm_acc_s) begin
        warm_r <= warm_r + WW'(1);
      end
      if (post_acc_s) begin
        phase_r <= (phase_r == PW'(DECIM - 1)) ? PW'(0) : phase_r + PW'(1);
      end
      if (push_s) begin
        mem_r[wr_ptr_r] <= scaled_s[OUT_W-1:0];
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (keep_s && scaled_s[OUT_W]) begin
        sat <= 1'b1;
      end
      if (drop_s) begin
        ovf <= 1'b1;
      end
      rd_ptr_r  <= rd_nxt_s;
      level     <= level_nxt_s;
      out_valid <= (level_nxt_s != LW'(0));
      if (level_nxt_s != LW'(0)) begin
        dout <= head_s;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Directed, table-driven bench for fir_out_conditioner with default parameters.
module tb_fir_out_conditioner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_en = 1'b0;
  logic [17:0] din = 18'd0;
  logic [7:0]  dout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  logic        ovf;
  logic        sat;

  int checks = 0;
  int errors = 0;
  logic [7:0] got [$];
  int exp_q [$];

  typedef struct {
    logic [17:0] din;
    int          exp_dout;
    int          exp_sat;
  } vec_t;
  vec_t vt [9];

  fir_out_conditioner dut (
    .clk(clk), .reset(reset), .in_en(in_en), .din(din), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .ovf(ovf), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, log the value the consumer takes at this edge.
  task automatic cyc(input logic en, input logic [17:0] d, input logic rdy);
    in_en = en;
    din = d;
    out_ready = rdy;
    if (out_valid && rdy) got.push_back(dout);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_en = 1'b1;
    din = 18'd999;
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_en = 1'b0;
    got.delete();
  endtask

  task automatic warm(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 18'd0, 1'b0);
  endtask

  task automatic chk_q(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk(name, int'(got[i]), exp_q[i]);
    end
  endtask

  initial begin
    vt[0] = '{18'd95,     1,   0};
    vt[1] = '{18'd96,     2,   0};
    vt[2] = '{18'd1500,   23,  0};
    vt[3] = '{18'd63,     1,   0};
    vt[4] = '{18'd31,     0,   0};
    vt[5] = '{18'd16351,  255, 0};
    vt[6] = '{18'd16352,  255, 1};
    vt[7] = '{18'h3FFFF,  255, 1};
    vt[8] = '{18'd0,      0,   1};

    // Reset state
    do_reset();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_sat", int'(sat), 0);

    // Ramp 1..20: small values round to zero
    for (int k = 1; k <= 20; k++) cyc(1'b1, 18'(k), 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 18'd0, 1'b1);
    exp_q = '{0, 0, 0, 0, 0};
    chk_q("ramp_small");

    // Ramp 64*k: kept k = 11,13,...,19
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b1, 18'(64 * k), 1'b1);
      if (k == 10) chk("warm_level", int'(level), 0);
      if (k == 11) begin
        chk("latency_valid", int'(out_valid), 1);
        chk("latency_dout", int'(dout), 11);
      end
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, 18'd0, 1'b1);
    exp_q = '{11, 13, 15, 17, 19};
    chk_q("ramp_scaled");

    // Rounding / saturation table
    do_reset();
    warm(10);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, vt[i].din, 1'b1);
      chk($sformatf("vec%0d_dout", i), int'(dout), vt[i].exp_dout);
      chk($sformatf("vec%0d_sat", i), int'(sat), vt[i].exp_sat);
      chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      cyc(1'b1, 18'd0, 1'b1);
      chk($sformatf("vec%0d_drain", i), int'(level), 0);
    end
    do_reset();
    chk("sat_cleared", int'(sat), 0);

    // Back-pressure: fifth kept sample is dropped
    warm(10);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 18'(64 * i), 1'b0);
      chk($sformatf("bp_level%0d", i), int'(level), (i > 4) ? 4 : i);
      chk($sformatf("bp_ovf%0d", i), int'(ovf), (i == 5) ? 1 : 0);
      chk($sformatf("bp_hold%0d", i), int'(dout), 1);
      cyc(1'b1, 18'd0, 1'b0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 18'd0, 1'b1);
    chk("bp_empty_valid", int'(out_valid), 0);
    chk("bp_empty_level", int'(level), 0);
    exp_q = '{1, 2, 3, 4};
    chk_q("bp_order");

    // Full with simultaneous pop
    do_reset();
    warm(10);
    for (int i = 10; i <= 13; i++) begin
      cyc(1'b1, 18'(64 * i), 1'b0);
      cyc(1'b1, 18'd0, 1'b0);
    end
    chk("full_level", int'(level), 4);
    cyc(1'b1, 18'(64 * 14), 1'b1);
    chk("fullpop_level", int'(level), 4);
    chk("fullpop_ovf", int'(ovf), 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 18'd0, 1'b1);
    exp_q = '{10, 11, 12, 13, 14};
    chk_q("fullpop_order");

    // Reset mid-stream with level=3, then warm-up with gaps
    do_reset();
    warm(10);
    cyc(1'b1, 18'd64, 1'b0);
    cyc(1'b1, 18'd0, 1'b0);
    cyc(1'b1, 18'd128, 1'b0);
    cyc(1'b1, 18'd0, 1'b0);
    cyc(1'b1, 18'h3FFFF, 1'b0);
    chk("mid_level", int'(level), 3);
    chk("mid_sat", int'(sat), 1);
    do_reset();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_sat", int'(sat), 0);
    for (int j = 0; j < 10; j++) begin
      cyc(1'b1, 18'(64 * 40), 1'b1);
      cyc(1'b0, 18'(64 * 41), 1'b1);
    end
    chk("gap_warm_level", int'(level), 0);
    cyc(1'b1, 18'(64 * 7), 1'b1);
    chk("gap_first_valid", int'(out_valid), 1);
    chk("gap_first_dout", int'(dout), 7);
    cyc(1'b0, 18'(64 * 33), 1'b1);
    cyc(1'b1, 18'(64 * 8), 1'b1);
    cyc(1'b0, 18'(64 * 34), 1'b1);
    chk("gap_skip_level", int'(level), 0);
    cyc(1'b1, 18'(64 * 9), 1'b1);
    chk("gap_keep_dout", int'(dout), 9);
    chk("gap_keep_level", int'(level), 1);
    cyc(1'b0, 18'd0, 1'b1);
    exp_q = '{7, 9};
    chk_q("gap_order");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
